// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache block fetcher.
//   state_t            : miss-controller states
//   BLOCK_W / WORD_W   : line and instruction word widths
//   WORD_SEL_LSB/BITS  : byte-address field selecting the word within a line
//   INDEX_LSB          : first byte-address bit of the line index
//   line_word()        : picks one 32-bit word out of a line (word 0 = bits [31:0])
package icache_pkg;

  localparam int BLOCK_W        = 128;
  localparam int WORD_W         = 32;
  localparam int WORDS_PER_LINE = BLOCK_W / WORD_W;
  localparam int WORD_SEL_LSB   = 2;
  localparam int WORD_SEL_BITS  = 2;
  localparam int INDEX_LSB      = WORD_SEL_LSB + WORD_SEL_BITS;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_t;

  function automatic logic [WORD_W-1:0] line_word(
    input logic [BLOCK_W-1:0]       line,
    input logic [WORD_SEL_BITS-1:0] sel
  );
    logic [WORDS_PER_LINE-1:0][WORD_W-1:0] words;
    words = line;
    return words[sel];
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data storage for a direct-mapped cache.
//   clock, reset      : rising-edge clock, async active-high reset (clears valid bits only)
//   clear             : invalidate every line at the next edge; wins over a same-cycle write
//   rd_index          : combinational read port index -> rd_valid, rd_tag, rd_data
//   wr_en/wr_index/wr_tag/wr_data : single write port, installs a line and marks it valid
module icache_line_store
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 3,
  parameter int TAG_W      = 25
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [BLOCK_W-1:0]    rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [BLOCK_W-1:0]    wr_data
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]              valid_q;
  logic [LINES-1:0][TAG_W-1:0]   tag_q;
  logic [LINES-1:0][BLOCK_W-1:0] data_q;

  // Per-line valid bit: a flush arriving with the refill write leaves the
  // freshly written line invalid too.
  for (genvar l = 0; l < LINES; l++) begin : g_line
    logic wr_hit;
    assign wr_hit = wr_en && (wr_index == l[INDEX_BITS-1:0]);

    always_ff @(posedge clock or posedge reset) begin
      if (reset)       valid_q[l] <= 1'b0;
      else if (clear)  valid_q[l] <= 1'b0;
      else if (wr_hit) valid_q[l] <= 1'b1;
    end

    // Tag and data need no reset: valid gates every use of them.
    always_ff @(posedge clock) begin
      if (wr_hit) begin
        tag_q[l]  <= wr_tag;
        data_q[l] <= wr_data;
      end
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/icache_block_fetcher.sv
// Direct-mapped instruction cache with its miss controller.
//   clock, reset        : rising-edge clock, async active-high reset
//   cpu_read/cpu_address: fetch request, held until busywait is low
//   flush               : invalidate all lines (deferred to end of refill if a miss is in flight)
//   readdata/busywait   : instruction word (zero-latency on hit) and CPU stall
//   mem_read/mem_address: block read request to instruction memory
//   mem_readdata/mem_busywait : block data and memory busy
module icache_block_fetcher
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 3,
  parameter int ADDR_W     = 32,
  parameter int MEM_ADDR_W = ADDR_W - 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_read,
  input  logic [ADDR_W-1:0]     cpu_address,
  input  logic                  flush,
  output logic [WORD_W-1:0]     readdata,
  output logic                  busywait,
  output logic                  mem_read,
  output logic [MEM_ADDR_W-1:0] mem_address,
  input  logic [BLOCK_W-1:0]    mem_readdata,
  input  logic                  mem_busywait
);

  localparam int TAG_W = ADDR_W - INDEX_LSB - INDEX_BITS;

  state_t                  state, state_nx;
  logic [MEM_ADDR_W-1:0]   miss_addr;
  logic                    flush_pending;
  logic                    miss_start;
  logic                    clear_all;

  logic [INDEX_BITS-1:0]   cpu_index;
  logic [TAG_W-1:0]        cpu_tag;
  logic                    rd_valid;
  logic [TAG_W-1:0]        rd_tag;
  logic [BLOCK_W-1:0]      rd_data;
  logic                    hit;
  logic                    unused_byte_sel;

  assign cpu_index       = cpu_address[INDEX_LSB +: INDEX_BITS];
  assign cpu_tag         = cpu_address[ADDR_W-1 -: TAG_W];
  assign unused_byte_sel = ^cpu_address[WORD_SEL_LSB-1:0];

  icache_line_store #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W)
  ) u_store (
    .clock    (clock),
    .reset    (reset),
    .clear    (clear_all),
    .rd_index (cpu_index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (state == UPDATE),
    .wr_index (miss_addr[INDEX_BITS-1:0]),
    .wr_tag   (miss_addr[MEM_ADDR_W-1:INDEX_BITS]),
    .wr_data  (mem_readdata)
  );

  assign hit      = rd_valid && (rd_tag == cpu_tag);
  assign readdata = (state == IDLE && hit)
                  ? line_word(rd_data, cpu_address[WORD_SEL_LSB +: WORD_SEL_BITS])
                  : '0;

  // Flush in IDLE acts at once; a flush seen mid-miss (now or earlier) is
  // applied on the UPDATE edge so it also kills the line being installed.
  assign clear_all = (state == IDLE && flush) ||
                     (state == UPDATE && (flush || flush_pending));

  assign mem_address = miss_addr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                          flush_pending <= 1'b0;
    else if (state == UPDATE)           flush_pending <= 1'b0;
    else if (flush && state != IDLE)    flush_pending <= 1'b1;
  end

  // Refill is driven purely from this latch, so the CPU may wander mid-miss.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)           miss_addr <= '0;
    else if (miss_start) miss_addr <= cpu_address[ADDR_W-1:INDEX_LSB];
  end

  always_comb begin
    state_nx   = state;
    busywait   = 1'b0;
    mem_read   = 1'b0;
    miss_start = 1'b0;
    unique case (state)
      IDLE: begin
        if (flush) begin
          busywait = 1'b1;
        end else if (cpu_read && !hit) begin
          busywait   = 1'b1;
          miss_start = 1'b1;
          state_nx   = MEM_READ;
        end
      end
      MEM_READ: begin
        busywait = 1'b1;
        mem_read = 1'b1;
        // Dropping mem_read on this edge parks the memory's byte counter.
        if (!mem_busywait) state_nx = UPDATE;
      end
      UPDATE: begin
        busywait = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // The stall is combinational from cpu_read; hold it low during reset.
    if (reset) busywait = 1'b0;
  end

endmodule
